// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: default FIFO geometry/threshold constants and count-width helper
package param_fifo_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AE_THRESH = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/param_fifo_mem.sv
// param_fifo_mem: unreset storage, one write port, one registered read port (holds when re=0); ports clk, we/waddr/wdata, re/raddr, rdata
module param_fifo_mem #(
  parameter int W = 16,
  parameter int D = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO, 1-cycle read latency, registered ack/overflow/underflow pulses, combinational status; clk/rst, data_in/wr_en/rd_en in, data_out/wr_ack/overflow/underflow/full/empty/almostfull/almostempty out; PARAM_FIFO_COUNT_EN adds count output
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = FIFO_DEPTH - 2,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
`ifdef PARAM_FIFO_COUNT_EN
  ,
  output logic [cnt_w(FIFO_DEPTH)-1:0] count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
  if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 || AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_params
    $error("param_fifo: illegal FIFO_WIDTH/FIFO_DEPTH/AE_THRESH/AF_THRESH");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [FIFO_WIDTH-1:0] rdata;
  logic dout_vld;
  logic wr_acc, rd_acc;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign almostfull = cnt >= CW'(AF_THRESH) && !full;
  assign almostempty = !empty && cnt <= CW'(AE_THRESH);
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;
  // storage read register has no reset, so data_out reads zero until the first accepted read after reset
  assign data_out = dout_vld ? rdata : '0;
`ifdef PARAM_FIFO_COUNT_EN
  assign count = cnt;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      dout_vld <= 1'b0;
      wr_ack <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + AW'(1);
      if (wr_acc && !rd_acc) cnt <= cnt + CW'(1);
      else if (rd_acc && !wr_acc) cnt <= cnt - CW'(1);
      dout_vld <= dout_vld | rd_acc;
      wr_ack <= wr_acc;
      overflow <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end
  param_fifo_mem #(.W(FIFO_WIDTH), .D(FIFO_DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re(rd_acc),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo at 16x8, AF=6, AE=2
module tb_param_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] data_in = '0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [15:0] data_out;
  logic wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
`ifdef PARAM_FIFO_COUNT_EN
  logic [3:0] count;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  param_fifo dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_out(data_out),
    .wr_ack(wr_ack),
    .overflow(overflow),
    .underflow(underflow),
    .full(full),
    .empty(empty),
    .almostfull(almostfull),
    .almostempty(almostempty)
`ifdef PARAM_FIFO_COUNT_EN
    ,
    .count(count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // status packed as {full, empty, almostfull, almostempty} for a known occupancy c
  task automatic check_status(input string tag, input int c);
    logic [3:0] exp;
    exp = {c == 8, c == 0, c >= 6 && c < 8, c >= 1 && c <= 2};
    check(tag, {28'd0, full, empty, almostfull, almostempty}, {28'd0, exp});
`ifdef PARAM_FIFO_COUNT_EN
    check({tag, "_cnt"}, {28'd0, count}, c);
`endif
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    check("rst_dout", data_out, 0);
    check("rst_pulses", {wr_ack, overflow, underflow}, 0);
    check_status("rst_status", 0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      data_in = 16'(i);
      tick();
      check($sformatf("wr%0d_ack", i), wr_ack, 1);
      check_status($sformatf("wr%0d_status", i), i);
    end
    data_in = 16'hDEAD;
    tick();
    check("ovf_pulse", {wr_ack, overflow}, 2'b01);
    check_status("ovf_status", 8);
    wr_en = 1'b0;
    tick();
    check("ovf_clear", {wr_ack, overflow}, 0);
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      check($sformatf("rd%0d_data", i), data_out, i);
      check_status($sformatf("rd%0d_status", i), 8 - i);
    end
    tick();
    check("udf_pulse", underflow, 1);
    check("udf_hold", data_out, 8);
    rd_en = 1'b0;
    tick();
    check("udf_clear", underflow, 0);
    check("idle_hold", data_out, 8);
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 16'h00AA;
    tick();
    check("ewr_pulses", {wr_ack, overflow, underflow}, 3'b101);
    check("ewr_dout", data_out, 8);
    check_status("ewr_status", 1);
    wr_en = 1'b0;
    tick();
    check("ewr_read", data_out, 16'h00AA);
    check_status("ewr_empty", 0);
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      data_in = 16'(16'h11 + i);
      tick();
    end
    check_status("refill_full", 8);
    rd_en = 1'b1;
    data_in = 16'h1234;
    tick();
    check("fwr_data", data_out, 16'h0011);
    check("fwr_pulses", {wr_ack, overflow, underflow}, 3'b100);
    check_status("fwr_status", 8);
    wr_en = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("wrap_rd%0d", i), data_out, 16'h11 + i);
    end
    tick();
    check("wrap_1234", data_out, 16'h1234);
    check_status("wrap_empty", 0);
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      data_in = 16'(16'h50 + i);
      tick();
    end
    check_status("pre_rst5", 5);
    check("pre_rst_ack", wr_ack, 1);
    data_in = 16'h0099;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_dout", data_out, 0);
    check("mid_rst_pulses", {wr_ack, overflow, underflow}, 0);
    check_status("mid_rst_status", 0);
    tick();
    wr_en = 1'b0;
    check_status("rst_hold", 0);
    rst = 1'b0;
    wr_en = 1'b1;
    data_in = 16'h0077;
    tick();
    check("post_rst_ack", wr_ack, 1);
    check("post_rst_dout", data_out, 0);
    check_status("post_rst_status", 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    check("post_rst_read", data_out, 16'h0077);
    check_status("post_rst_empty", 0);
    tick();
    check("post_rst_udf", underflow, 1);
    rd_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 FIFO_WIDTH, 16, data bits per entry; SHALL be >= 1.
REQ-002 FIFO_DEPTH, 8, number of entries; SHALL be >= 2; non-power-of-2 values SHALL be supported.
REQ-003 AF_THRESH, FIFO_DEPTH-2, occupancy at which almostfull asserts.
REQ-004 AE_THRESH, 2, occupancy at or below which almostempty asserts.
REQ-005 Elaboration SHALL fail unless 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1.
REQ-006 One clock; reset is asynchronous and active-high; ports SHALL be clk and rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  async active-high reset.
REQ-009 data_in  input  FIFO_WIDTH  write data.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request.
REQ-012 data_out  output  FIFO_WIDTH  registered read data.
REQ-013 wr_ack  output  1  registered pulse, previous-cycle write accepted.
REQ-014 overflow  output  1  registered pulse, previous-cycle write rejected.
REQ-015 underflow  output  1  registered pulse, previous-cycle read rejected.
REQ-016 full, empty, almostfull, almostempty  output  1 each  combinational status from occupancy.

Function
REQ-017 Occupancy count SHALL be $clog2(FIFO_DEPTH+1) bits, range 0..FIFO_DEPTH.
REQ-018 Write accepted iff wr_en && (!full || rd_en); accepted write stores data_in at wr_ptr, advances wr_ptr.
REQ-019 Read accepted iff rd_en && !empty; accepted read loads data_out with entry at rd_ptr on the same edge, advances rd_ptr (1-cycle read latency).
REQ-020 data_out SHALL hold its value when no read is accepted.
REQ-021 Both pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-022 Full with wr_en && rd_en: both accepted, count unchanged, wr_ack=1, overflow=0.
REQ-023 Empty with wr_en && rd_en: write accepted, read rejected, underflow=1, data_out unchanged; no bypass.
REQ-024 Count: +1 write only, -1 read only, unchanged for both or neither.
REQ-025 wr_ack = accepted write; overflow = wr_en && !accepted write; underflow = rd_en && !accepted read; each valid for exactly the cycle after the request.
REQ-026 full = (count == FIFO_DEPTH); empty = (count == 0).
REQ-027 almostfull = (count >= AF_THRESH) && !full.
REQ-028 almostempty = (count != 0) && (count <= AE_THRESH).

Reset
REQ-029 rst assertion SHALL immediately clear pointers, count, data_out, wr_ack, overflow, underflow; empty=1, full=0, almostfull=0, almostempty=0.
REQ-030 Storage array SHALL NOT be reset; rst mid-operation discards all contents.
REQ-031 First accepted operation SHALL occur on the first clk edge after rst deasserts.

Configuration
REQ-032 Macro PARAM_FIFO_COUNT_EN defined: output port count ($clog2(FIFO_DEPTH+1) bits) SHALL expose live occupancy, reset 0.
REQ-033 Macro undefined: port count SHALL not exist; all other behaviour identical.

Structure
REQ-034 Package param_fifo_pkg SHALL hold default width/depth/threshold constants and the count-width function.
REQ-035 Storage SHALL be sub-module param_fifo_mem: one write port, one synchronous read port, no reset.

Verification (WIDTH=16, DEPTH=8, AF=6, AE=2)
REQ-036 Write 0x0001..0x0008, then 8 reads -> wr_ack 8 pulses, full after 8th write, data_out 0x0001..0x0008 in order, empty after last read.
REQ-037 Full, one more write 0xDEAD -> overflow=1 one cycle, wr_ack=0, count stays 8, 0xDEAD never read.
REQ-038 Empty, rd_en -> underflow=1 one cycle, data_out unchanged; empty, wr_en+rd_en with 0x00AA -> count 1, underflow=1, next read returns 0x00AA.
REQ-039 Full, wr_en+rd_en 0x1234 -> oldest entry out, count 8, wr_ack=1; 0x1234 emerges on 8th later read (pointer wrap).
REQ-040 Thresholds: almostempty at counts 1-2, almostfull at 6-7, both 0 at 0, 3-5, and 8.
REQ-041 rst pulse at count 5 mid-write -> all outputs at reset values immediately; next write/read returns new data only.
